// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit peripheral: register offsets,
// transmit FSM state encoding and configuration reset defaults.
package uart_pkg;

    // Register byte offsets within the peripheral
    localparam logic [31:0] ADDR_DATA   = 32'h0000_0000;
    localparam logic [31:0] ADDR_READY  = 32'h0000_0004;
    localparam logic [31:0] ADDR_BUSY   = 32'h0000_0008;
    localparam logic [31:0] ADDR_BAUD   = 32'h0000_000C;
    localparam logic [31:0] ADDR_PARITY = 32'h0000_0010;
    localparam logic [31:0] ADDR_STOP   = 32'h0000_0014;
    localparam logic [31:0] ADDR_RST    = 32'h0000_0024;

    // Configuration values after reset or soft reset
    localparam logic [16:0] BAUD_RESET   = 17'd9600;
    localparam logic        PARITY_RESET = 1'b1;
    localparam logic        STOP_RESET   = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART transmit engine: fractional baud accumulator, frame FSM and data shift
// register. Accepts a byte through a valid/ready handshake; ready is offered in
// IDLE and on the final tick of the last stop bit so frames can run back-to-back.
// clear_i is a synchronous abort that returns the engine to IDLE with the line high.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 10_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [16:0] baudrate_i,
    input  logic        parity_en_i,
    input  logic        stopbit_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        tx_o
);

    localparam logic [31:0] ClkFreq = 32'(CLK_FREQ_HZ);

    tx_state_e   state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] acc_sum;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        par_q, par_d;
    logic        par_en_q, par_en_d;
    logic        stop2_q, stop2_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        tick;
    logic        last_stop;
    logic        fire;

    // Baud tick fires when the accumulator would reach the clock frequency
    assign acc_sum   = acc_q + {15'b0, baudrate_i};
    assign tick      = (state_q != StIdle) && (acc_sum >= ClkFreq);
    // Second stop bit only exists when two stop bits were latched for this frame
    assign last_stop = (state_q == StStop) && (!stop2_q || stop_cnt_q);
    assign fire      = valid_i && ready_o;

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    // Next-state: frame sequencing, bit shifting and accumulator update
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;

        // Accumulator rests at zero in IDLE, so every frame from IDLE starts clean
        if (state_q == StIdle) begin
            acc_d = '0;
        end else if (tick) begin
            acc_d = acc_sum - ClkFreq;
        end else begin
            acc_d = acc_sum;
        end

        if (fire) begin
            state_d    = StStart;
            shift_d    = data_i;
            par_d      = even_parity(data_i);
            par_en_d   = parity_en_i;
            stop2_d    = stopbit_i;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
        end else begin
            case (state_q)
                StStart: begin
                    if (tick) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    if (tick) begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d    = par_en_q ? StParity : StStop;
                            stop_cnt_d = 1'b0;
                        end
                    end
                end
                StParity: begin
                    if (tick) begin
                        state_d    = StStop;
                        stop_cnt_d = 1'b0;
                    end
                end
                StStop: begin
                    if (tick) begin
                        if (last_stop) begin
                            state_d = StIdle;
                        end else begin
                            stop_cnt_d = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (clear_i) begin
            state_d    = StIdle;
            acc_d      = '0;
            shift_d    = '0;
            bit_cnt_d  = '0;
            par_d      = 1'b0;
            par_en_d   = 1'b0;
            stop2_d    = 1'b0;
            stop_cnt_d = 1'b0;
        end
    end

    // Outputs: line level per state, handshake and busy flag
    always_comb begin
        ready_o = (state_q == StIdle) || (last_stop && tick);
        busy_o  = (state_q != StIdle);
        case (state_q)
            StIdle:   tx_o = 1'b1;
            StStart:  tx_o = 1'b0;
            StData:   tx_o = shift_q[0];
            StParity: tx_o = par_q;
            StStop:   tx_o = 1'b1;
            default:  tx_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_tx_sb_ctrl.sv
// System-bus UART transmit controller: register decode, configuration
// registers, transmit buffer and completion interrupt around uart_tx_core.
// Build option UART_TX_FIFO_EN: when defined the buffer is a FIFO_DEPTH-entry
// circular FIFO, otherwise a single holding register with a valid bit.
module uart_tx_sb_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 10_000_000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        write_enable_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        interrupt_request_o,
    input  logic        interrupt_return_i,
    output logic        tx_o
);

    logic        wr, rd, wr_data, soft_rst;
    logic        push, pop;
    logic        buf_ready, buf_empty, busy;
    logic [7:0]  core_data;
    logic        core_ready, core_busy;

    logic [16:0] baud_q, baud_d;
    logic        parity_q, parity_d;
    logic        stop_q, stop_d;
    logic        irq_q, irq_d;
    logic        busy_prev_q, busy_prev_d;
    logic [31:0] rdata_q, rdata_d;

    // Upper write-data bits carry no register content
    logic        unused_wdata;
    assign unused_wdata = ^write_data_i[31:17];

    assign wr       = req_i && write_enable_i;
    assign rd       = req_i && !write_enable_i;
    assign wr_data  = wr && (addr_i == ADDR_DATA);
    assign soft_rst = wr && (addr_i == ADDR_RST);
    assign busy     = core_busy || !buf_empty;
    assign pop      = !buf_empty && core_ready;
    // A pop in the same cycle frees a slot, so a full buffer still takes the push
    assign push     = wr_data && (buf_ready || pop);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    assign buf_ready = (count_q < CntW'(FIFO_DEPTH));
    assign buf_empty = (count_q == '0);
    assign core_data = mem_q[rptr_q];

    // FIFO storage, written at the write pointer
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= write_data_i[7:0];
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Pointers wrap naturally since the depth is a power of two
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (soft_rst) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end
`else
    localparam int unsigned unused_depth = FIFO_DEPTH;

    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;

    assign buf_ready = !valid_q;
    assign buf_empty = !valid_q;
    assign core_data = hold_q;

    // Single holding register with valid flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    // Pop is applied before push so a simultaneous pair refills the register
    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (push) begin
            hold_d  = write_data_i[7:0];
            valid_d = 1'b1;
        end
        if (soft_rst) begin
            valid_d = 1'b0;
        end
    end
`endif

    // Control registers: config, IRQ, busy history, read data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            baud_q      <= BAUD_RESET;
            parity_q    <= PARITY_RESET;
            stop_q      <= STOP_RESET;
            irq_q       <= 1'b0;
            busy_prev_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            baud_q      <= baud_d;
            parity_q    <= parity_d;
            stop_q      <= stop_d;
            irq_q       <= irq_d;
            busy_prev_q <= busy_prev_d;
            rdata_q     <= rdata_d;
        end
    end

    // Config writes are locked out while a transmission is pending or running
    always_comb begin
        baud_d   = baud_q;
        parity_d = parity_q;
        stop_d   = stop_q;
        if (wr && !busy) begin
            case (addr_i)
                ADDR_BAUD:   baud_d   = write_data_i[16:0];
                ADDR_PARITY: parity_d = write_data_i[0];
                ADDR_STOP:   stop_d   = write_data_i[0];
                default:     ;
            endcase
        end
        if (soft_rst) begin
            baud_d   = BAUD_RESET;
            parity_d = PARITY_RESET;
            stop_d   = STOP_RESET;
        end
    end

    // IRQ on the engine falling back to IDLE; an aborted frame must not raise it
    always_comb begin
        busy_prev_d = soft_rst ? 1'b0 : core_busy;
        irq_d       = irq_q;
        if (interrupt_return_i || wr_data) begin
            irq_d = 1'b0;
        end
        if (busy_prev_q && !core_busy) begin
            irq_d = 1'b1;
        end
        if (soft_rst) begin
            irq_d = 1'b0;
        end
    end

    // Registered read mux; holds its value between reads
    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            case (addr_i)
                ADDR_READY:  rdata_d = {31'b0, buf_ready};
                ADDR_BUSY:   rdata_d = {31'b0, busy};
                ADDR_BAUD:   rdata_d = {15'b0, baud_q};
                ADDR_PARITY: rdata_d = {31'b0, parity_q};
                ADDR_STOP:   rdata_d = {31'b0, stop_q};
                default:     rdata_d = '0;
            endcase
        end
    end

    assign read_data_o         = rdata_q;
    assign interrupt_request_o = irq_q;

    uart_tx_core #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_core (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (soft_rst),
        .baudrate_i  (baud_q),
        .parity_en_i (parity_q),
        .stopbit_i   (stop_q),
        .data_i      (core_data),
        .valid_i     (!buf_empty),
        .ready_o     (core_ready),
        .busy_o      (core_busy),
        .tx_o        (tx_o)
    );

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Self-checking bench for uart_tx_sb_ctrl. The baud register is 17 bits wide, so
// a 1 MHz clock with 100 kbaud stands in for a 10 clock-per-bit line.
module tb_uart_tx_sb_ctrl;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam logic [31:0] BAUD   = 32'd100_000;
`ifdef UART_TX_FIFO_EN
    localparam int B2B_FRAMES = 5;
`else
    localparam int B2B_FRAMES = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic        irq_ret;
    logic        tx;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    uart_tx_sb_ctrl #(
        .CLK_FREQ_HZ (CLK_HZ),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .req_i               (req),
        .addr_i              (addr),
        .write_enable_i      (we),
        .write_data_i        (wdata),
        .read_data_o         (rdata),
        .interrupt_request_o (irq),
        .interrupt_return_i  (irq_ret),
        .tx_o                (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a;
        @(posedge clk);
        #1;
        req = 1'b0;
        check(name, rdata, exp);
    endtask

    // Waits for the start bit, then samples mid-bit every 10 clocks
    task automatic check_frame(input logic [31:0] syms, input int n, input string name,
                               output int unsigned start_cyc);
        int guard = 0;
        while (tx === 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        start_cyc = cyc;
        if (tx !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s start: tx=%b never went low (required 0)", name, tx);
        end else begin
            repeat (4) @(negedge clk);
            for (int k = 0; k < n; k++) begin
                check($sformatf("%s sym%0d", name, k), {31'b0, tx}, {31'b0, syms[k]});
                if (k < n - 1) repeat (10) @(negedge clk);
            end
        end
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    // Line idles at start+nsym*10; IRQ follows one clock later
    task automatic check_irq_after(input int unsigned st, input int nsym, input string name);
        wait_until(st + 10 * nsym);
        check({name, " irq before"}, {31'b0, irq}, 32'd0);
        check({name, " tx idle"}, {31'b0, tx}, 32'd1);
        @(negedge clk);
        check({name, " irq set"}, {31'b0, irq}, 32'd1);
    endtask

    initial begin
        int unsigned st;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; irq_ret = 1'b0;

        vecs[0]  = '{1'b0, 32'h0C, 32'h0, 32'd9600};
        vecs[1]  = '{1'b0, 32'h10, 32'h0, 32'd1};
        vecs[2]  = '{1'b0, 32'h14, 32'h0, 32'd1};
        vecs[3]  = '{1'b0, 32'h04, 32'h0, 32'd1};
        vecs[4]  = '{1'b0, 32'h08, 32'h0, 32'd0};
        vecs[5]  = '{1'b0, 32'h00, 32'h0, 32'd0};
        vecs[6]  = '{1'b0, 32'h24, 32'h0, 32'd0};
        vecs[7]  = '{1'b0, 32'h18, 32'h0, 32'd0};
        vecs[8]  = '{1'b1, 32'h0C, 32'hFFFF_86A0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0C, 32'h0, BAUD};
        vecs[10] = '{1'b1, 32'h10, 32'hFFFF_FFFE, 32'h0};
        vecs[11] = '{1'b0, 32'h10, 32'h0, 32'd0};
        vecs[12] = '{1'b1, 32'h14, 32'h0000_0002, 32'h0};
        vecs[13] = '{1'b0, 32'h14, 32'h0, 32'd0};

        repeat (3) @(negedge clk);
        check("reset tx", {31'b0, tx}, 32'd1);
        check("reset irq", {31'b0, irq}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        rst = 1'b0;

        // Register reads after reset, then config writes with masked readback
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                check_read($sformatf("vec%0d rd 0x%0h", i, vecs[i].addr), vecs[i].addr,
                           vecs[i].exp);
            end
        end

        // 0xA5, no parity, one stop bit
        bus_write(32'h00, 32'hA5);
        check_frame(32'h34A, 10, "a5", st);
        check_irq_after(st, 10, "a5");

        // 0x55, even parity, two stop bits; config locked while busy
        bus_write(32'h10, 32'd1);
        bus_write(32'h14, 32'd1);
        check("irq held by cfg write", {31'b0, irq}, 32'd1);
        bus_write(32'h00, 32'h55);
        check("irq cleared by push", {31'b0, irq}, 32'd0);
        fork
            check_frame(32'hCAA, 12, "55p", st);
            begin
                repeat (20) @(negedge clk);
                check_read("busy mid frame", 32'h08, 32'd1);
                bus_write(32'h0C, 32'h1234);
                check_read("baud locked", 32'h0C, BAUD);
                check_read("busy late frame", 32'h08, 32'd1);
            end
        join
        check_irq_after(st, 12, "55p");
        @(negedge clk);
        irq_ret = 1'b1;
        @(negedge clk);
        irq_ret = 1'b0;
        check("irq return", {31'b0, irq}, 32'd0);
        check_read("busy idle", 32'h08, 32'd0);
        bus_write(32'h0C, 32'h1234);
        check_read("baud idle write", 32'h0C, 32'h1234);
        bus_write(32'h0C, BAUD);
        bus_write(32'h10, 32'd0);
        bus_write(32'h14, 32'd0);

        // Back-to-back frames 0x11, 0x22; extra pushes beyond capacity are dropped
        fork
            check_frame(32'h91222, 20, "b2b", st);
            begin
                bus_write(32'h00, 32'h11);
                bus_write(32'h00, 32'h22);
                bus_write(32'h00, 32'h33);
`ifdef UART_TX_FIFO_EN
                bus_write(32'h00, 32'h44);
                bus_write(32'h00, 32'h55);
                bus_write(32'h00, 32'h66);
`endif
                check_read("ready when full", 32'h04, 32'd0);
            end
        join
        check_irq_after(st, 10 * B2B_FRAMES, "b2b");

        // read_data_o holds between reads and across writes
        check_read("baud readback", 32'h0C, BAUD);
        repeat (5) @(negedge clk);
        check("rdata hold idle", rdata, BAUD);
        bus_write(32'h10, 32'd0);
        check("rdata hold write", rdata, BAUD);

        // Soft reset mid-frame
        bus_write(32'h00, 32'h00);
        repeat (30) @(negedge clk);
        check("tx low before soft rst", {31'b0, tx}, 32'd0);
        bus_write(32'h24, 32'h0);
        check("soft rst tx", {31'b0, tx}, 32'd1);
        check("soft rst irq", {31'b0, irq}, 32'd0);
        check_read("soft rst busy", 32'h08, 32'd0);
        check_read("soft rst baud", 32'h0C, 32'd9600);
        check_read("soft rst parity", 32'h10, 32'd1);
        check_read("soft rst stop", 32'h14, 32'd1);
        check_read("soft rst ready", 32'h04, 32'd1);
        repeat (20) @(negedge clk);
        check("no resume after soft rst", {31'b0, tx}, 32'd1);
        check("no irq after soft rst", {31'b0, irq}, 32'd0);

        // Hard reset mid-frame drives the line high without waiting for a clock
        bus_write(32'h0C, BAUD);
        bus_write(32'h00, 32'h00);
        repeat (20) @(negedge clk);
        check("tx low before rst", {31'b0, tx}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async rst tx", {31'b0, tx}, 32'd1);
        check("async rst rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_read("rst baud", 32'h0C, 32'd9600);
        repeat (15) @(negedge clk);
        check("no resume after rst", {31'b0, tx}, 32'd1);
        check_read("rst busy", 32'h08, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
